// File: rtl/grn_floyd_ctrl.sv
// Floyd cycle-detection sequencer for a bank of GRN nodes: steps tortoise/hare state vectors,
// then measures the attractor period once they meet.
module grn_floyd_ctrl #(
  parameter int unsigned N_NODES   = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STEPS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] seed,
  input  logic [N_NODES-1:0] s0_i,
  input  logic [N_NODES-1:0] s1_i,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   meet_steps,
  output logic [CNT_W-1:0]   period
);

  typedef enum logic [2:0] {
    StIdle, StInit, StRunA, StRunB, StCmp1, StPerStep, StCmp2, StDone
  } state_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_STEPS);

  state_e             state_q, state_d;
  logic [N_NODES-1:0] seed_q, seed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   meet_q, meet_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               match;

  // One counter serves both phases; it restarts from zero when the meet is found.
  assign cnt_inc = (cnt_q >= MaxCnt) ? MaxCnt : cnt_q + 1'b1;
  assign match   = (s0_i == s1_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      seed_q    <= '0;
      cnt_q     <= '0;
      meet_q    <= '0;
      period_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      cnt_q     <= cnt_d;
      meet_q    <= meet_d;
      period_q  <= period_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    cnt_d     = cnt_q;
    meet_d    = meet_q;
    period_d  = period_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StInit;
          seed_d    = seed;
          timeout_d = 1'b0;
          meet_d    = '0;
          period_d  = '0;
        end
      end
      StInit: begin
        cnt_d   = '0;
        state_d = StRunA;
      end
      StRunA: state_d = StRunB;
      StRunB: state_d = StCmp1;
      StCmp1: begin
        cnt_d = cnt_inc;
        if (match) begin
          meet_d  = cnt_inc;
          cnt_d   = '0;
          state_d = StPerStep;
        end else if (cnt_inc == MaxCnt) begin
          timeout_d = 1'b1;
          meet_d    = MaxCnt;
          period_d  = '0;
          state_d   = StDone;
        end else begin
          state_d = StRunA;
        end
      end
      StPerStep: state_d = StCmp2;
      StCmp2: begin
        cnt_d = cnt_inc;
        if (match) begin
          period_d = cnt_inc;
          state_d  = StDone;
        end else if (cnt_inc == MaxCnt) begin
          timeout_d = 1'b1;
          period_d  = '0;
          state_d   = StDone;
        end else begin
          state_d = StPerStep;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Node controls depend on the state register alone.
  assign reset_nos  = (state_q == StInit);
  assign init_state = reset_nos ? seed_q : '0;
  assign start_s0   = (state_q == StRunA) || (state_q == StRunB);
  assign start_s1   = start_s0 || (state_q == StPerStep);
  assign busy       = (state_q != StIdle) && (state_q != StDone);
  assign done       = (state_q == StDone);
  assign timeout    = timeout_q;
  assign meet_steps = meet_q;
  assign period     = period_q;

endmodule

// File: tb/tb_grn_floyd_ctrl.sv
// Directed bench for grn_floyd_ctrl: two controllers (default and short step limit) each driving a
// 3-node behavioural network with tortoise/hare registers and a pass flag.
module tb_grn_floyd_ctrl;

  localparam int N = 3;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic [N-1:0] seed;
  int fmode;
  logic clr_cnt;

  logic [N-1:0] s0_a, s1_a, init_a, s0_b, s1_b, init_b;
  logic pass_a, pass_b;
  logic rn_a, st0_a, st1_a, busy_a, done_a, to_a;
  logic rn_b, st0_b, st1_b, busy_b, done_b, to_b;
  logic [W-1:0] meet_a, per_a, meet_b, per_b;
  int ps0_a, ps1_a, ps0_b;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  grn_floyd_ctrl #(.N_NODES(N), .CNT_W(W), .MAX_STEPS(1000)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .seed(seed), .s0_i(s0_a), .s1_i(s1_a),
    .reset_nos(rn_a), .init_state(init_a), .start_s0(st0_a), .start_s1(st1_a),
    .busy(busy_a), .done(done_a), .timeout(to_a), .meet_steps(meet_a), .period(per_a)
  );

  grn_floyd_ctrl #(.N_NODES(N), .CNT_W(W), .MAX_STEPS(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .seed(seed), .s0_i(s0_b), .s1_i(s1_b),
    .reset_nos(rn_b), .init_state(init_b), .start_s0(st0_b), .start_s1(st1_b),
    .busy(busy_b), .done(done_b), .timeout(to_b), .meet_steps(meet_b), .period(per_b)
  );

  function automatic logic [N-1:0] f(input logic [N-1:0] x);
    case (fmode)
      0:       f = x;
      1:       f = x + 3'd1;
      default: f = (x == 3'd4) ? 3'd2 : x + 3'd1;
    endcase
  endfunction

  // Behavioural node bank: tortoise moves on every second start_s0 pulse after reset_nos.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_a <= '0; s1_a <= '0; pass_a <= 1'b0;
    end else if (rn_a) begin
      s0_a <= init_a; s1_a <= init_a; pass_a <= 1'b1;
    end else begin
      if (st0_a) begin
        pass_a <= ~pass_a;
        if (pass_a) s0_a <= f(s0_a);
      end
      if (st1_a) s1_a <= f(s1_a);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_b <= '0; s1_b <= '0; pass_b <= 1'b0;
    end else if (rn_b) begin
      s0_b <= init_b; s1_b <= init_b; pass_b <= 1'b1;
    end else begin
      if (st0_b) begin
        pass_b <= ~pass_b;
        if (pass_b) s0_b <= f(s0_b);
      end
      if (st1_b) s1_b <= f(s1_b);
    end
  end

  always_ff @(posedge clk) begin
    if (clr_cnt) begin
      ps0_a <= 0; ps1_a <= 0; ps0_b <= 0;
    end else begin
      if (st0_a) ps0_a <= ps0_a + 1;
      if (st1_a) ps1_a <= ps1_a + 1;
      if (st0_b) ps0_b <= ps0_b + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch a run and return the cycle (relative to the accepting cycle) at which done is seen.
  task automatic run_seed(input bit use_b, input logic [N-1:0] sd, input bit glitch,
                          output int cyc);
    int n;
    n = 0;
    cyc = -1;
    @(negedge clk);
    seed = sd;
    clr_cnt = 1'b1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      clr_cnt = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      if (glitch && (n == 4 || n == 26)) start_a = 1'b1;
      if (n == 1) begin
        check_eq("init_busy", use_b ? busy_b : busy_a, 1);
        check_eq("init_done_clr", use_b ? done_b : done_a, 0);
        check_eq("init_meet_clr", use_b ? meet_b : meet_a, 0);
        if (!use_b) begin
          check_eq("init_reset_nos", rn_a, 1);
          check_eq("init_state", init_a, sd);
        end
      end
      if (use_b ? done_b : done_a) begin
        cyc = n;
        break;
      end
    end
    if (cyc < 0) check_eq("done_bound", 0, 1);
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    seed = '0;
    fmode = 0;
    clr_cnt = 1'b1;
    #3;
    check_eq("reset_outs_a", {rn_a, init_a, st0_a, st1_a, busy_a, done_a, to_a, meet_a, per_a}, 0);
    check_eq("reset_outs_b", {rn_b, init_b, st0_b, st1_b, busy_b, done_b, to_b, meet_b, per_b}, 0);
    @(negedge clk);
    rst = 1'b1;

    // Fixed point: meets immediately.
    fmode = 0;
    run_seed(0, 3'd5, 0, cyc);
    check_eq("t1_cycle", cyc, 7);
    check_eq("t1_meet", meet_a, 1);
    check_eq("t1_period", per_a, 1);
    check_eq("t1_timeout", to_a, 0);
    check_eq("t1_busy", busy_a, 0);
    check_eq("t1_s1_pulses", ps1_a, 3);

    // Pure 8-cycle.
    fmode = 1;
    run_seed(0, 3'd0, 0, cyc);
    check_eq("t2_cycle", cyc, 42);
    check_eq("t2_meet", meet_a, 8);
    check_eq("t2_period", per_a, 8);
    check_eq("t2_timeout", to_a, 0);
    check_eq("t2_s0_pulses", ps0_a, 16);
    check_eq("t2_s1_pulses", ps1_a, 24);

    // Tail of two into a 3-cycle.
    fmode = 2;
    run_seed(0, 3'd0, 0, cyc);
    check_eq("t3_cycle", cyc, 17);
    check_eq("t3_meet", meet_a, 3);
    check_eq("t3_period", per_a, 3);
    check_eq("t3_s0_pulses", ps0_a, 6);
    check_eq("t3_s1_pulses", ps1_a, 9);

    // Step limit of 4 on the second controller.
    fmode = 1;
    run_seed(1, 3'd0, 0, cyc);
    check_eq("t4_cycle", cyc, 14);
    check_eq("t4_timeout", to_b, 1);
    check_eq("t4_meet", meet_b, 4);
    check_eq("t4_period", per_b, 0);
    check_eq("t4_s0_pulses", ps0_b, 8);

    // Spurious start pulses in CMP1 and PER_STEP must not disturb the run.
    run_seed(0, 3'd0, 1, cyc);
    check_eq("t6_cycle", cyc, 42);
    check_eq("t6_meet", meet_a, 8);
    check_eq("t6_period", per_a, 8);

    // Asynchronous reset during RUN_B.
    @(negedge clk);
    seed = 3'd0;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check_eq("t5_in_runb", st1_a, 1);
    rst = 1'b0;
    #1;
    check_eq("t5_reset_outs", {rn_a, init_a, st0_a, st1_a, busy_a, done_a, to_a, meet_a, per_a}, 0);
    @(negedge clk);
    rst = 1'b1;
    run_seed(0, 3'd0, 0, cyc);
    check_eq("t5_cycle", cyc, 42);
    check_eq("t5_meet", meet_a, 8);
    check_eq("t5_period", per_a, 8);
    check_eq("t5_timeout", to_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
